// File: rtl/aibcr3_dll_pkg.sv
// Shared definitions for the DLL delay-code controller: code field widths,
// FSM state encoding, coarse step size and the binary-to-gray helper.
package aibcr3_dll_pkg;

    localparam int unsigned CODE_W      = 10;
    localparam int unsigned COARSE_W    = 7;
    localparam int unsigned FINE_W      = 3;
    localparam int unsigned COARSE_STEP = 8;

    // Legacy state encodings, kept so existing netlist probes still decode.
    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SETTLE_ENC = 2'd1;
    localparam logic [1:0] ST_SAMPLE_ENC = 2'd2;
    localparam logic [1:0] ST_UPDATE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_SETTLE = ST_SETTLE_ENC,
        ST_SAMPLE = ST_SAMPLE_ENC,
        ST_UPDATE = ST_UPDATE_ENC
    } dll_state_e;

    // Gray encode; narrower fields are zero-extended in and truncated out.
    function automatic logic [COARSE_W-1:0] bin2gray(input logic [COARSE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/aibcr3_dll_vote_acc.sv
// Phase-detector vote accumulator: signed running sum of +1/-1 votes and a
// sample counter. done_o flags the sample that completes a VOTE_N window,
// so the accumulator already holds the full sum on the following cycle.
module aibcr3_dll_vote_acc #(
    parameter int unsigned VOTE_N = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear_i,
    input  logic                              sample_i,
    input  logic                              up_i,
    output logic signed [$clog2(VOTE_N)+1:0]  acc_o,
    output logic                              done_o
);

    localparam int unsigned ACC_W = $clog2(VOTE_N) + 2;
    localparam int unsigned CNT_W = $clog2(VOTE_N) + 1;
    localparam logic signed [ACC_W-1:0] ONE = 1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    assign done_o = sample_i && (cnt_q == CNT_W'(VOTE_N - 1));
    assign acc_o  = acc_q;

    // Next-state for the vote sum and window sample count
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_i) begin
            acc_d = up_i ? acc_q + ONE : acc_q - ONE;
            cnt_d = done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Accumulator and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aibcr3_dll_code_ctrl.sv
// DLL delay-code controller: settles, collects a window of phase-detector
// votes, then nudges a 10-bit delay code and drives its gray-coded coarse
// and fine fields to the delay line. Tracks direction reversals for lock.
// Optional AIBCR3_DLL_COARSE_STEP_EN: steps by a full coarse step until the
// first direction reversal after reset or enable rising edge.
module aibcr3_dll_code_ctrl
    import aibcr3_dll_pkg::*;
#(
    parameter logic [CODE_W-1:0] CODE_MAX   = 10'd511,
    parameter int unsigned       SETTLE_CYC = 8,
    parameter int unsigned       VOTE_N     = 16,
    parameter int unsigned       LOCK_REV   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CODE_W-1:0]   init_code,
    input  logic                pd_valid,
    input  logic                pd_up,
    output logic [COARSE_W-1:0] sm_grey,
    output logic [FINE_W-1:0]   sm_igray,
    output logic                code_valid,
    output logic                locked,
    output logic                sat
);

    localparam int unsigned ACC_W  = $clog2(VOTE_N) + 2;
    localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int unsigned REV_W  = $clog2(LOCK_REV + 1);
    localparam int unsigned SAME_W = $clog2(2 * LOCK_REV + 1);

    dll_state_e           state_q, state_d;
    logic [CODE_W-1:0]    code_q, code_d, init_clamped, step, code_up, code_dn;
    logic [COARSE_W-1:0]  grey_q;
    logic [FINE_W-1:0]    igray_q;
    logic                 cv_q, cv_d, locked_q, locked_d, sat_q, sat_d, en_q;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [REV_W-1:0]     rev_q, rev_d;
    logic [SAME_W-1:0]    same_q, same_d;
    logic                 prev_up_q, prev_up_d, have_prev_q, have_prev_d;
    logic signed [ACC_W-1:0] acc;
    logic                 acc_done, sample_en, acc_clear;
    logic                 dir_up, dir_dn, upd_active, reversal;

    assign init_clamped = (init_code > CODE_MAX) ? CODE_MAX : init_code;
    assign sample_en    = enable && (state_q == ST_SAMPLE) && pd_valid;
    assign acc_clear    = !enable || (state_q == ST_UPDATE) || (state_q == ST_IDLE);

    aibcr3_dll_vote_acc #(.VOTE_N(VOTE_N)) u_vote (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (acc_clear),
        .sample_i (sample_en),
        .up_i     (pd_up),
        .acc_o    (acc),
        .done_o   (acc_done)
    );

    assign dir_up     = acc > 0;
    assign dir_dn     = acc < 0;
    assign upd_active = enable && (state_q == ST_UPDATE);
    assign reversal   = upd_active && (dir_up || dir_dn) && have_prev_q && (dir_up != prev_up_q);

`ifdef AIBCR3_DLL_COARSE_STEP_EN
    logic fast_q;

    // Fast acquisition armed on reset/enable rise, dropped at first reversal
    always_ff @(posedge clk) begin
        if (rst)                   fast_q <= 1'b1;
        else if (enable && !en_q)  fast_q <= 1'b1;
        else if (reversal)         fast_q <= 1'b0;
    end

    assign step = fast_q ? CODE_W'(COARSE_STEP) : CODE_W'(1);
`else
    assign step = CODE_W'(1);
`endif

    // Saturating candidates; the clamp can land short of a full step
    assign code_up = ((CODE_MAX - code_q) < step) ? CODE_MAX : code_q + step;
    assign code_dn = (code_q < step) ? '0 : code_q - step;

    // FSM sequencing, code update and lock/saturation bookkeeping
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        cv_d        = 1'b0;
        locked_d    = locked_q;
        sat_d       = sat_q;
        settle_d    = settle_q;
        rev_d       = rev_q;
        same_d      = same_q;
        prev_up_d   = prev_up_q;
        have_prev_d = have_prev_q;
        if (!enable) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                    if (!en_q) begin
                        code_d      = init_clamped;
                        cv_d        = 1'b1;
                        locked_d    = 1'b0;
                        rev_d       = '0;
                        same_d      = '0;
                        prev_up_d   = 1'b0;
                        have_prev_d = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                        state_d  = ST_SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (acc_done) state_d = ST_UPDATE;
                end
                ST_UPDATE: begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                    if (dir_up) code_d = code_up;
                    if (dir_dn) code_d = code_dn;
                    if (dir_up || dir_dn) begin
                        cv_d  = (code_d != code_q);
                        sat_d = (code_d == code_q);
                        if (reversal) begin
                            if (rev_q != REV_W'(LOCK_REV)) rev_d = rev_q + REV_W'(1);
                            same_d = '0;
                            if (rev_d == REV_W'(LOCK_REV)) locked_d = 1'b1;
                        end else if (have_prev_q) begin
                            rev_d = '0;
                            if (same_q != SAME_W'(2 * LOCK_REV)) same_d = same_q + SAME_W'(1);
                            if (same_d == SAME_W'(2 * LOCK_REV)) locked_d = 1'b0;
                        end
                        prev_up_d   = dir_up;
                        have_prev_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers; gray fields registered alongside the code they encode
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            code_q      <= init_clamped;
            grey_q      <= bin2gray(init_clamped[CODE_W-1:FINE_W]);
            igray_q     <= FINE_W'(bin2gray(COARSE_W'(init_clamped[FINE_W-1:0])));
            cv_q        <= 1'b0;
            locked_q    <= 1'b0;
            sat_q       <= 1'b0;
            en_q        <= 1'b0;
            settle_q    <= '0;
            rev_q       <= '0;
            same_q      <= '0;
            prev_up_q   <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            grey_q      <= bin2gray(code_d[CODE_W-1:FINE_W]);
            igray_q     <= FINE_W'(bin2gray(COARSE_W'(code_d[FINE_W-1:0])));
            cv_q        <= cv_d;
            locked_q    <= locked_d;
            sat_q       <= sat_d;
            en_q        <= enable;
            settle_q    <= settle_d;
            rev_q       <= rev_d;
            same_q      <= same_d;
            prev_up_q   <= prev_up_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign sm_grey    = grey_q;
    assign sm_igray   = igray_q;
    assign code_valid = cv_q;
    assign locked     = locked_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_aibcr3_dll_code_ctrl.sv
// Directed bench for the DLL delay-code controller. Inputs change and outputs
// are observed on the falling clock edge. A vote window is 8 settle cycles,
// 16 sample cycles (plus any pd_valid gaps) and one update cycle.
module tb_aibcr3_dll_code_ctrl;

    logic       clk = 1'b0;
    logic       rst, enable, pd_valid, pd_up;
    logic [9:0] init_code;
    logic [6:0] sm_grey;
    logic [2:0] sm_igray;
    logic       code_valid, locked, sat;
    int         n_tests = 0;
    int         n_fail  = 0;

`ifdef AIBCR3_DLL_COARSE_STEP_EN
    localparam int FAST = 8;
`else
    localparam int FAST = 1;
`endif

    always #5 clk = ~clk;

    aibcr3_dll_code_ctrl #(
        .CODE_MAX   (10'd511),
        .SETTLE_CYC (8),
        .VOTE_N     (16),
        .LOCK_REV   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .init_code  (init_code),
        .pd_valid   (pd_valid),
        .pd_up      (pd_up),
        .sm_grey    (sm_grey),
        .sm_igray   (sm_igray),
        .code_valid (code_valid),
        .locked     (locked),
        .sat        (sat)
    );

    // Decode the observed gray fields back to the binary code.
    function automatic int code_now();
        logic [6:0] c;
        logic [2:0] f;
        c[6] = sm_grey[6];
        for (int i = 5; i >= 0; i--) c[i] = c[i+1] ^ sm_grey[i];
        f[2] = sm_igray[2];
        f[1] = f[2] ^ sm_igray[1];
        f[0] = f[1] ^ sm_igray[0];
        return int'({c, f});
    endfunction

    task automatic do_reset(input logic [9:0] ic);
        rst = 1'b1; enable = 1'b0; pd_valid = 1'b0; pd_up = 1'b0; init_code = ic;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_enable();
        enable = 1'b1;
        @(negedge clk);
    endtask

    // One full window: settle cycles carry contrary votes that must be ignored.
    task automatic run_window(input int n_up, input int gaps, output int early);
        early = 0;
        for (int i = 0; i < 8; i++) begin
            pd_valid = 1'b1; pd_up = (n_up < 8);
            @(negedge clk); if (code_valid) early++;
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                for (int g = 0; g < gaps; g++) begin
                    pd_valid = 1'b0; pd_up = (n_up < 8);
                    @(negedge clk); if (code_valid) early++;
                end
            end
            pd_valid = 1'b1; pd_up = (i < n_up);
            @(negedge clk); if (code_valid) early++;
        end
        pd_valid = 1'b1; pd_up = (n_up < 8);
        @(negedge clk);
        pd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(10'd100);
        n_tests++; if (sm_grey !== 7'b0001010) begin n_fail++; $display("FAIL reset_grey: got %b expected %b", sm_grey, 7'b0001010); end
        n_tests++; if (sm_igray !== 3'b110) begin n_fail++; $display("FAIL reset_igray: got %b expected %b", sm_igray, 3'b110); end
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cv: got %b expected 0", code_valid); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", sat); end
        do_reset(10'd700);
        n_tests++; if (code_now() !== 511) begin n_fail++; $display("FAIL reset_clamp: got %0d expected 511", code_now()); end
    endtask

    task automatic test_up_tracking();
        int early;
        do_reset(10'd100);
        start_enable();
        n_tests++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL enable_cv: got %b expected 1", code_valid); end
        n_tests++; if (code_now() !== 100) begin n_fail++; $display("FAIL enable_code: got %0d expected 100", code_now()); end
        run_window(16, 0, early);
        n_tests++; if (early !== 0) begin n_fail++; $display("FAIL up_early: got %0d pulses expected 0", early); end
        n_tests++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL up_cv: got %b expected 1", code_valid); end
        n_tests++; if (code_now() !== 100 + FAST) begin n_fail++; $display("FAIL up_code: got %0d expected %0d", code_now(), 100 + FAST); end
    endtask

    task automatic test_tie();
        int early;
        run_window(8, 0, early);
        n_tests++; if (early !== 0) begin n_fail++; $display("FAIL tie_early: got %0d pulses expected 0", early); end
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL tie_cv: got %b expected 0", code_valid); end
        n_tests++; if (code_now() !== 100 + FAST) begin n_fail++; $display("FAIL tie_code: got %0d expected %0d", code_now(), 100 + FAST); end
    endtask

    task automatic test_lock();
        int early;
        int ups[6]  = '{16, 0, 8, 16, 0, 16};
        int gap[6]  = '{3, 0, 0, 0, 0, 0};
        int codes[6];
        logic lk[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        codes = '{200 + FAST, 200, 200, 201, 200, 201};
        do_reset(10'd200);
        start_enable();
        for (int w = 0; w < 6; w++) begin
            run_window(ups[w], gap[w], early);
            n_tests++; if (code_now() !== codes[w]) begin n_fail++; $display("FAIL lock_code w%0d: got %0d expected %0d", w, code_now(), codes[w]); end
            n_tests++; if (locked !== lk[w]) begin n_fail++; $display("FAIL lock_flag w%0d: got %b expected %b", w, locked, lk[w]); end
        end
        for (int k = 1; k <= 8; k++) begin
            run_window(16, 0, early);
            n_tests++; if (code_now() !== 201 + k) begin n_fail++; $display("FAIL unlock_code k%0d: got %0d expected %0d", k, code_now(), 201 + k); end
            n_tests++; if (locked !== (k < 8)) begin n_fail++; $display("FAIL unlock_flag k%0d: got %b expected %b", k, locked, (k < 8)); end
        end
        do_reset(10'd200);
        start_enable();
        for (int w = 0; w < 5; w++) run_window((w % 2 == 0) ? 16 : 0, 0, early);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %b expected 1", locked); end
        enable = 1'b0;
        @(negedge clk);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_enfall: got %b expected 0", locked); end
    endtask

    task automatic test_saturation();
        int early;
        do_reset(10'd511);
        start_enable();
        for (int w = 0; w < 2; w++) begin
            run_window(16, 0, early);
            n_tests++; if (code_now() !== 511) begin n_fail++; $display("FAIL sat_hi_code w%0d: got %0d expected 511", w, code_now()); end
            n_tests++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_hi_flag w%0d: got %b expected 1", w, sat); end
            n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL sat_hi_cv w%0d: got %b expected 0", w, code_valid); end
        end
        run_window(0, 0, early);
        n_tests++; if (code_now() !== 511 - FAST) begin n_fail++; $display("FAIL sat_release_code: got %0d expected %0d", code_now(), 511 - FAST); end
        n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_release_flag: got %b expected 0", sat); end
        n_tests++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL sat_release_cv: got %b expected 1", code_valid); end
        do_reset(10'd0);
        start_enable();
        run_window(0, 0, early);
        n_tests++; if (code_now() !== 0) begin n_fail++; $display("FAIL sat_lo_code: got %0d expected 0", code_now()); end
        n_tests++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_lo_flag: got %b expected 1", sat); end
        // Reset in the middle of the next window.
        for (int i = 0; i < 12; i++) begin
            pd_valid = 1'b1; pd_up = 1'b0; @(negedge clk);
        end
        do_reset(10'd100);
        n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL midrst_sat: got %b expected 0", sat); end
        n_tests++; if (code_now() !== 100) begin n_fail++; $display("FAIL midrst_code: got %0d expected 100", code_now()); end
        start_enable();
        run_window(16, 0, early);
        n_tests++; if (code_now() !== 100 + FAST) begin n_fail++; $display("FAIL midrst_window: got %0d expected %0d", code_now(), 100 + FAST); end
    endtask

    task automatic test_interrupt();
        int early;
        int pulses;
        do_reset(10'd300);
        start_enable();
        run_window(16, 0, early);
        n_tests++; if (code_now() !== 300 + FAST) begin n_fail++; $display("FAIL int_pre_code: got %0d expected %0d", code_now(), 300 + FAST); end
        for (int i = 0; i < 14; i++) begin
            pd_valid = 1'b1; pd_up = 1'b0; @(negedge clk);
        end
        enable = 1'b0;
        @(negedge clk);
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL int_cv: got %b expected 0", code_valid); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            pd_valid = i[0]; pd_up = 1'b0; @(negedge clk);
            if (code_valid) pulses++;
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL int_idle_pulses: got %0d expected 0", pulses); end
        n_tests++; if (code_now() !== 300 + FAST) begin n_fail++; $display("FAIL int_hold: got %0d expected %0d", code_now(), 300 + FAST); end
        pd_valid = 1'b0;
        start_enable();
        n_tests++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL int_reen_cv: got %b expected 1", code_valid); end
        n_tests++; if (code_now() !== 300) begin n_fail++; $display("FAIL int_reload: got %0d expected 300", code_now()); end
        run_window(8, 0, early);
        n_tests++; if (early !== 0 || code_valid !== 1'b0) begin n_fail++; $display("FAIL int_acc_clear: got early=%0d cv=%b expected 0/0", early, code_valid); end
        n_tests++; if (code_now() !== 300) begin n_fail++; $display("FAIL int_after_tie: got %0d expected 300", code_now()); end
    endtask

    task automatic test_coarse();
        int early;
        int ups[6] = '{16, 16, 16, 0, 0, 16};
        int exp_code[6];
        exp_code = '{FAST, 2 * FAST, 3 * FAST, 2 * FAST, 2 * FAST - 1, 2 * FAST};
        do_reset(10'd0);
        start_enable();
        for (int w = 0; w < 6; w++) begin
            run_window(ups[w], 0, early);
            n_tests++; if (code_now() !== exp_code[w]) begin n_fail++; $display("FAIL coarse_code w%0d: got %0d expected %0d", w, code_now(), exp_code[w]); end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; pd_valid = 1'b0; pd_up = 1'b0; init_code = '0;
        @(negedge clk);
        test_reset();
        test_up_tracking();
        test_tie();
        test_lock();
        test_saturation();
        test_interrupt();
        test_coarse();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
